// File: rtl/riscv_reg_file.sv
// RV32I integer register file: two combinational read ports, one clocked write port.
// x0 reads as zero, and a write in flight is bypassed to the read ports in the same cycle.
module riscv_reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] reg1_addr_i,
  input  logic [ADDR_W-1:0] reg2_addr_i,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  input  logic [ADDR_W-1:0] writereg_addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_write_i
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              wr_en;

  // A write to x0 is dropped here, so regs_q[0] stays zero forever.
  assign wr_en = data_write_i && (writereg_addr_i != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[writereg_addr_i] = data_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic              rst_ok,
    input logic [ADDR_W-1:0] addr,
    input logic              we,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] result;
    if (!rst_ok || addr == '0) begin
      result = '0;
    end else if (we && waddr == addr) begin
      result = wdata;
    end else begin
      result = stored;
    end
    return result;
  endfunction

  // Reset gates the outputs too, so reads are zero even before the flops respond.
  always_comb begin
    data1_o = read_port(reset_n, reg1_addr_i, data_write_i, writereg_addr_i,
                        data_i, regs_q[reg1_addr_i]);
    data2_o = read_port(reset_n, reg2_addr_i, data_write_i, writereg_addr_i,
                        data_i, regs_q[reg2_addr_i]);
  end

endmodule

// File: tb/tb_riscv_reg_file.sv
// Self-checking bench for riscv_reg_file: directed test-plan steps, then random traffic
// against an array model of the 32 architectural registers.
module tb_riscv_reg_file;

  logic        clk;
  logic        reset_n;
  logic [4:0]  reg1_addr_i;
  logic [4:0]  reg2_addr_i;
  logic [31:0] data1_o;
  logic [31:0] data2_o;
  logic [4:0]  writereg_addr_i;
  logic [31:0] data_i;
  logic        data_write_i;

  int vectors;
  int miscompares;
  logic [31:0] model [32];

  riscv_reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .reg1_addr_i     (reg1_addr_i),
    .reg2_addr_i     (reg2_addr_i),
    .data1_o         (data1_o),
    .data2_o         (data2_o),
    .writereg_addr_i (writereg_addr_i),
    .data_i          (data_i),
    .data_write_i    (data_write_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural view of a read port, straight from the register-file rules.
  function automatic logic [31:0] expectedRead(input logic [4:0] addr);
    if (!reset_n) return 32'h0;
    if (addr == 5'd0) return 32'h0;
    if (data_write_i && writereg_addr_i == addr) return data_i;
    return model[addr];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] ra1, input logic [4:0] ra2,
                               input logic we, input logic [4:0] wa,
                               input logic [31:0] din);
    reg1_addr_i     = ra1;
    reg2_addr_i     = ra2;
    data_write_i    = we;
    writereg_addr_i = wa;
    data_i          = din;
  endtask

  task automatic checkPorts(input string tag);
    #1;
    checkOutput({tag, "_p1"}, data1_o, expectedRead(reg1_addr_i));
    checkOutput({tag, "_p2"}, data2_o, expectedRead(reg2_addr_i));
  endtask

  // Advance one rising edge, commit any legal write to the model, then settle.
  task automatic tick();
    @(posedge clk);
    if (reset_n && data_write_i && writereg_addr_i != 5'd0)
      model[writereg_addr_i] = data_i;
    #1;
  endtask

  task automatic pulseReset();
    reset_n = 1'b0;
    foreach (model[k]) model[k] = 32'h0;
    #1;
    checkOutput("reset_live_p1", data1_o, 32'h0);
    checkOutput("reset_live_p2", data2_o, 32'h0);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    foreach (model[k]) model[k] = 32'h0;
    reset_n = 1'b0;
    applyStimulus(5'd5, 5'd9, 1'b1, 5'd5, 32'hCAFEF00D);
    #1;
    checkOutput("in_reset_p1", data1_o, 32'h0);
    checkOutput("in_reset_p2", data2_o, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("reset_write_discarded", data1_o, 32'h0);
    #2;
    reset_n = 1'b1;
    applyStimulus(5'd5, 5'd9, 1'b0, 5'd0, 32'h0);
    checkPorts("after_release");

    // Reset clears a written register
    applyStimulus(5'd5, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    applyStimulus(5'd5, 5'd5, 1'b0, 5'd0, 32'h0);
    checkOutput("x5_written", data1_o, 32'hDEADBEEF);
    pulseReset();
    #1;
    checkOutput("x5_after_reset", data1_o, 32'h00000000);

    // x0 immutable
    applyStimulus(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
    #1;
    checkOutput("x0_during_write", data1_o, 32'h0);
    tick();
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("x0_after_write", data1_o, 32'h0);

    // Write / readback on both ports
    applyStimulus(5'd0, 5'd0, 1'b1, 5'd1, 32'h12345678);
    tick();
    applyStimulus(5'd0, 5'd0, 1'b1, 5'd31, 32'h80000000);
    tick();
    applyStimulus(5'd1, 5'd31, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("x1_readback", data1_o, 32'h12345678);
    checkOutput("x31_readback", data2_o, 32'h80000000);

    // Same-cycle bypass
    applyStimulus(5'd0, 5'd0, 1'b1, 5'd7, 32'h11111111);
    tick();
    applyStimulus(5'd7, 5'd7, 1'b1, 5'd7, 32'h22222222);
    #1;
    checkOutput("bypass_pre_p1", data1_o, 32'h22222222);
    checkOutput("bypass_pre_p2", data2_o, 32'h22222222);
    tick();
    data_write_i = 1'b0;
    #1;
    checkOutput("bypass_post_p1", data1_o, 32'h22222222);
    checkOutput("bypass_post_p2", data2_o, 32'h22222222);

    // Write enable gating
    applyStimulus(5'd3, 5'd3, 1'b0, 5'd3, 32'hABCD0000);
    tick();
    #1;
    checkOutput("we_gating_x3", data1_o, 32'h0);

    // Full sweep
    for (int i = 1; i < 32; i++) begin
      applyStimulus(5'd0, 5'd0, 1'b1, 5'(i), 32'(i) * 32'h01010101);
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      int j;
      j = (32 - i) % 32;
      applyStimulus(5'(i), 5'(j), 1'b0, 5'd0, 32'h0);
      #1;
      checkOutput($sformatf("sweep_x%0d", i), data1_o, 32'(i) * 32'h01010101);
      checkOutput($sformatf("sweep_x%0d", j), data2_o, 32'(j) * 32'h01010101);
    end

    // Random traffic with occasional mid-run resets
    for (int n = 0; n < 300; n++) begin
      applyStimulus(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      if ($urandom_range(0, 3) == 0) reg2_addr_i = writereg_addr_i;
      checkPorts($sformatf("rand%0d", n));
      tick();
      if ($urandom_range(0, 59) == 0) pulseReset();
    end

    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
    for (int i = 1; i < 32; i++) begin
      reg1_addr_i = 5'(i);
      #1;
      checkOutput($sformatf("final_x%0d", i), data1_o, model[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
